// File: rtl/window_gen_3x3.sv
// window_gen_3x3: raster-scan to 3x3 neighbourhood generator.
// Two line buffers feed a shifting 3x3 tap array; interior windows only.
module window_gen_3x3 #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DW-1:0]              pix_in,
    input  logic                       pix_valid,
    input  logic                       pix_sof,
    output logic [DW-1:0]              xm1ym1,
    output logic [DW-1:0]              xm1y0,
    output logic [DW-1:0]              xm1yp1,
    output logic [DW-1:0]              x0ym1,
    output logic [DW-1:0]              x0y0,
    output logic [DW-1:0]              x0yp1,
    output logic [DW-1:0]              xp1ym1,
    output logic [DW-1:0]              xp1y0,
    output logic [DW-1:0]              xp1yp1,
    output logic                       win_valid,
    output logic [$clog2(IMG_H)-1:0]   win_row,
    output logic [$clog2(IMG_W)-1:0]   win_col,
    output logic                       frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] C1   = CW'(1);
    localparam logic [RW-1:0] R1   = RW'(1);
    localparam logic [CW-1:0] C2   = CW'(2);
    localparam logic [RW-1:0] R2   = RW'(2);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] ec;
    logic [RW-1:0] er;
    logic          acc;
    logic          interior;
    logic          last;

    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];
    logic [DW-1:0] top_new;
    logic [DW-1:0] mid_new;

    // Effective position of this pixel: start-of-frame forces (0,0).
    always_comb begin
        acc      = pix_valid;
        ec       = pix_sof ? '0 : col;
        er       = pix_sof ? '0 : row;
        interior = (er >= R2) && (ec >= C2);
        last     = (er == RMAX) && (ec == CMAX);
    end

    assign top_new = lb2[ec];
    assign mid_new = lb1[ec];

    // Position of the next accepted pixel, wrapping at line and frame end.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (acc) begin
            if (ec == CMAX) begin
                col <= '0;
                row <= (er == RMAX) ? '0 : er + R1;
            end else begin
                col <= ec + C1;
                row <= er;
            end
        end
    end

    // Line buffers: lb1 holds the previous line, lb2 the one before it.
    always_ff @(posedge clk) begin
        if (acc) begin
            lb2[ec] <= lb1[ec];
            lb1[ec] <= pix_in;
        end
    end

    // Tap array shifts left; the new right column comes from the buffers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xm1ym1 <= '0;
            xm1y0  <= '0;
            xm1yp1 <= '0;
            x0ym1  <= '0;
            x0y0   <= '0;
            x0yp1  <= '0;
            xp1ym1 <= '0;
            xp1y0  <= '0;
            xp1yp1 <= '0;
        end else if (acc) begin
            xm1ym1 <= xm1y0;
            xm1y0  <= xm1yp1;
            xm1yp1 <= top_new;
            x0ym1  <= x0y0;
            x0y0   <= x0yp1;
            x0yp1  <= mid_new;
            xp1ym1 <= xp1y0;
            xp1y0  <= xp1yp1;
            xp1yp1 <= pix_in;
        end
    end

    // Window strobe, centre coordinates and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
        end else begin
            win_valid  <= acc && interior;
            frame_done <= acc && last;
            if (acc && interior) begin
                win_row <= er - R1;
                win_col <= ec - C1;
            end
        end
    end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Raster-scan to 3x3 neighbourhood generator; the producer side of the 3x3 window interface consumed by the median filter.
- Accepts one pixel per valid cycle in row-major order, buffers two previous lines and emits all nine window taps plus a window-valid strobe.
- Tap ports carry the same xm1ym1..xp1yp1 names the median filter consumes, so the two blocks connect port-to-port.

Parameters:
- IMG_W, 64, image width in pixels (>=3).
- IMG_H, 64, image height in lines (>=3).
- DW, 8, pixel width in bits.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- pix_in  in  DW  input pixel, unsigned.
- pix_valid  in  1  pix_in accepted this cycle; no backpressure, bubbles allowed.
- pix_sof  in  1  qualified by pix_valid; marks pixel (0,0) of a frame.
- xm1ym1, xm1y0, xm1yp1  out  DW each  top window row, left/centre/right.
- x0ym1, x0y0, x0yp1  out  DW each  middle window row; x0y0 is the centre pixel.
- xp1ym1, xp1y0, xp1yp1  out  DW each  bottom window row.
- win_valid  out  1  taps hold a complete interior window.
- win_row  out  $clog2(IMG_H)  row of the centre pixel.
- win_col  out  $clog2(IMG_W)  column of the centre pixel.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Axes: x = line offset (m1 = line above), y = column offset (m1 = column left).
- Counters: col (0..IMG_W-1) and row (0..IMG_H-1) give the position of the next accepted pixel. They advance only on pix_valid. col wraps to 0 and increments row. After (IMG_H-1, IMG_W-1) both wrap to (0,0).
- pix_valid and pix_sof together: the pixel is treated as (0,0) and counters restart. A partial frame is abandoned with no frame_done. pix_sof without pix_valid is ignored.
- Line buffers: two IMG_W-deep buffers, indexed by col. lb1 holds row r-1; lb2 holds row r-2.
  - On accept at (r,c): lb2[c] <= lb1[c]; lb1[c] <= pix_in.
  - Registers or inferred RAM; contents are not reset.
- Window shift: on accept at (r,c), the 3x3 register array shifts left one column. The new right column is top = lb2[c] (old), middle = lb1[c] (old), bottom = pix_in.
- After the shift, the array holds rows r-2..r and columns c-2..c. The centre is (r-1, c-1).
- Tap mapping after the shift:
  - xm1ym1 = (r-2, c-2); x0y0 = (r-1, c-1); xp1yp1 = (r, c).
  - The remaining taps follow the same row/column offsets.
- Valid strobe:
  - win_valid is registered. It is 1 in the cycle after an accept with r>=2 and c>=2, and 0 otherwise, including idle cycles.
  - win_row/win_col <= r-1 / c-1 on those accepts.
- Latency: exactly 1 clock from accepting pixel (r+1,c+1) to win_valid for centre (r,c).
- Window count: (IMG_W-2)*(IMG_H-2) windows per frame. Border centres are not emitted (no padding).
- Hold behaviour: taps, win_row and win_col keep their values when no pixel is accepted.
- Row wrap: stale columns from the previous row sit in the array for the first two pixels of a row. They are masked by the c>=2 rule and never emitted as valid.
- frame_done pulses in the cycle after accepting (IMG_H-1, IMG_W-1). It coincides with win_valid for centre (IMG_H-2, IMG_W-2).
- Reset (rst low, any time, asynchronous):
  - All taps 0, win_valid 0, win_row/win_col 0, frame_done 0.
  - Counters return to (0,0).
  - The first pixel after reset release is (0,0) whether or not pix_sof is set.
- Arithmetic: counters are unsigned and sized to their parameter; no overflow beyond the wrap points. Pixels pass through unmodified.

Test Plan:
- Reset: hold rst low with random pix_valid -> all outputs 0, win_valid never asserted.
- 4x4 frame (IMG_W=4, IMG_H=4), pixel value = 16*r+c, pix_sof on the first pixel, continuous valid:
  - win_valid goes high 1 cycle after pixel 10 is accepted, with xm1ym1=0x00, x0y0=0x11, xp1yp1=0x22, win_row=1, win_col=1.
  - Exactly 4 windows appear, centres (1,1),(1,2),(2,1),(2,2).
  - frame_done coincides with the (2,2) window, whose x0y0=0x22.
- Same frame with random pix_valid bubbles -> identical tap/row/col sequence; outputs hold between accepts; no extra win_valid pulses.
- pix_sof at pixel 6 of a 4x4 frame, then a full frame -> no frame_done for the aborted frame; the first window of the new frame appears after its (2,2) pixel with x0y0=0x11.
- Two back-to-back 4x4 frames without gaps, second with values +0x80 -> 8 windows and 2 frame_done pulses; the first window of frame 2 has x0y0=0x91, with no taps leaking from frame 1.
- Assert rst mid-frame (after pixel 9) -> win_valid low immediately, asynchronously; after release, the stream restarts at (0,0) and the window sequence matches the first 4x4 frame test.
